led_blink_sequencer: RTL and testbench

//  Controller for the 4-rate LED blinker: generates its enable and 2-bit rate select (switch_1/switch_2).
//  A debounced push-button starts/stops the sequence. Rate selects step either automatically after a dwell

---
 rtl/led_blink_sequencer.sv | 122 ++++++++++++
 tb/tb_led_blink_sequencer.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/led_blink_sequencer.sv
// Run/stop and rate-select controller for the 4-rate LED blinker.
// A debounced button starts/stops; the rate steps on dwell expiry (auto) or on each press (manual).
module led_blink_sequencer #(
  parameter int DWELL_CLKS    = 25000,
  parameter int DEBOUNCE_CLKS = 250
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_button,
  input  logic i_auto,
  output logic o_enable,
  output logic o_switch_1,
  output logic o_switch_2,
  output logic o_step,
  output logic o_running
);

  localparam int DW = $clog2(DWELL_CLKS);
  localparam int BW = $clog2(DEBOUNCE_CLKS);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CLKS - 1);
  localparam logic [BW-1:0] DB_LAST    = BW'(DEBOUNCE_CLKS - 1);

  typedef enum logic {ST_OFF, ST_RUN} state_t;

  logic          sync_1, btn_s, btn_db, btn_db_q, press;
  logic [BW-1:0] db_cnt;

  state_t        state, state_n;
  logic [1:0]    sel, sel_n;
  logic [DW-1:0] dwell, dwell_n;
  logic          step, step_n;

  // Synchroniser, debounce counter and rising-edge press detector.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      sync_1   <= 1'b0;
      btn_s    <= 1'b0;
      btn_db   <= 1'b0;
      btn_db_q <= 1'b0;
      press    <= 1'b0;
      db_cnt   <= '0;
    end else begin
      sync_1   <= i_button;
      btn_s    <= sync_1;
      btn_db_q <= btn_db;
      press    <= btn_db & ~btn_db_q;
      if (btn_s == btn_db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        btn_db <= btn_s;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + BW'(1);
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state <= ST_OFF;
      sel   <= 2'b00;
      dwell <= '0;
      step  <= 1'b0;
    end else begin
      state <= state_n;
      sel   <= sel_n;
      dwell <= dwell_n;
      step  <= step_n;
    end
  end

  always_comb begin
    state_n = state;
    sel_n   = sel;
    dwell_n = dwell;
    step_n  = 1'b0;
    case (state)
      ST_OFF: begin
        if (press) begin
          state_n = ST_RUN;
          sel_n   = 2'b00;
          dwell_n = '0;
        end
      end
      ST_RUN: begin
        if (i_auto) begin
          // A press on the dwell terminal cycle stops without stepping.
          if (press) begin
            state_n = ST_OFF;
            sel_n   = 2'b00;
            dwell_n = '0;
          end else if (dwell == DWELL_LAST) begin
            sel_n   = sel + 2'd1;
            dwell_n = '0;
            step_n  = 1'b1;
          end else begin
            dwell_n = dwell + DW'(1);
          end
        end else begin
          dwell_n = '0;
          if (press) begin
            if (sel != 2'b11) begin
              sel_n  = sel + 2'd1;
              step_n = 1'b1;
            end else begin
              state_n = ST_OFF;
              sel_n   = 2'b00;
            end
          end
        end
      end
      default: state_n = ST_OFF;
    endcase
  end

  assign o_enable   = (state == ST_RUN);
  assign o_running  = (state == ST_RUN);
  assign o_switch_1 = sel[1];
  assign o_switch_2 = sel[0];
  assign o_step     = step;

endmodule

// File: tb/tb_led_blink_sequencer.sv
// Directed bench for led_blink_sequencer with DWELL_CLKS=8, DEBOUNCE_CLKS=4.
// A button raised just after edge N acts on the FSM at edge N+8 (sync 2 + debounce 4 + press reg + FSM).
module tb_led_blink_sequencer;

  logic clk, rst, btn, auto_m;
  logic en, sw1, sw2, stp, run;
  logic [4:0] obs;
  int total = 0;
  int bad = 0;
  logic [1:0] sp, sn;
  logic [4:0] t3_exp [5] = '{5'b11000, 5'b11011, 5'b11101, 5'b11111, 5'b00000};
  logic [4:0] prev;

  led_blink_sequencer #(.DWELL_CLKS(8), .DEBOUNCE_CLKS(4)) dut (
    .i_clock(clk), .i_reset(rst), .i_button(btn), .i_auto(auto_m),
    .o_enable(en), .o_switch_1(sw1), .o_switch_2(sw2), .o_step(stp), .o_running(run)
  );

  // {enable, running, switch_1, switch_2, step}
  assign obs = {en, run, sw1, sw2, stp};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [4:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; btn = 1'b0; auto_m = 1'b0;
    // 1: reset and idle
    tick(3);
    chk("reset_state", 5'b00000);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      chk("idle_hold", 5'b00000);
    end

    // 2: auto mode, four steps including the wrap, then stop
    auto_m = 1'b1;
    btn = 1'b1;
    tick(7); chk("t2_pre_start", 5'b00000);
    tick(1); chk("t2_start", 5'b11000);
    btn = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      sp = 2'(k - 1);
      sn = 2'(k);
      tick(7); chk("t2_dwell", {2'b11, sp, 1'b0});
      tick(1); chk("t2_step", {2'b11, sn, 1'b1});
    end
    tick(1); chk("t2_step_clear", 5'b11000);
    btn = 1'b1;
    tick(7); chk("t2_step_before_stop", 5'b11011);
    tick(1); chk("t2_stop", 5'b00000);
    btn = 1'b0;
    tick(12); chk("t2_off_stays", 5'b00000);

    // 3: manual mode, five presses
    auto_m = 1'b0;
    prev = 5'b00000;
    for (int i = 0; i < 5; i++) begin
      btn = 1'b1;
      tick(7); chk("t3_pre", prev);
      tick(1); chk("t3_press", t3_exp[i]);
      btn = 1'b0;
      prev = t3_exp[i] & 5'b11110;
      tick(12); chk("t3_settle", prev);
    end

    // 4: bouncing press and release
    for (int i = 0; i < 5; i++) begin
      btn = 1'b1; tick(2);
      btn = 1'b0; tick(2);
    end
    tick(8); chk("t4_bounce_no_press", 5'b00000);
    btn = 1'b1;
    tick(10); chk("t4_hold_one_press", 5'b11000);
    for (int i = 0; i < 5; i++) begin
      btn = 1'b0; tick(2);
      btn = 1'b1; tick(2);
    end
    btn = 1'b0;
    tick(12); chk("t4_release_no_press", 5'b11000);

    // 5: press landing on the dwell terminal cycle
    rst = 1'b1;
    tick(1); chk("t5_reset_mid_run", 5'b00000);
    rst = 1'b0;
    auto_m = 1'b1;
    btn = 1'b1;
    tick(8); chk("t5_start", 5'b11000);
    btn = 1'b0;
    tick(8); chk("t5_first_step", 5'b11011);
    btn = 1'b1;
    tick(7); chk("t5_pre_collide", 5'b11010);
    tick(1); chk("t5_collide_off", 5'b00000);
    tick(1); chk("t5_no_step", 5'b00000);
    btn = 1'b0;
    tick(12);

    // 6: reset at sel=10, then auto toggling in RUN
    btn = 1'b1;
    tick(8); chk("t6_start", 5'b11000);
    btn = 1'b0;
    tick(16); chk("t6_sel10", 5'b11101);
    tick(2);
    rst = 1'b1;
    tick(1); chk("t6_reset", 5'b00000);
    rst = 1'b0;
    auto_m = 1'b0;
    btn = 1'b1;
    tick(8); chk("t6_manual_start", 5'b11000);
    btn = 1'b0;
    tick(12); chk("t6_manual_hold", 5'b11000);
    auto_m = 1'b1;
    tick(7); chk("t6_auto_pre", 5'b11000);
    tick(1); chk("t6_auto_step", 5'b11011);
    tick(3);
    auto_m = 1'b0;
    tick(2); chk("t6_auto_off_hold", 5'b11010);
    auto_m = 1'b1;
    tick(7); chk("t6_reauto_pre", 5'b11010);
    tick(1); chk("t6_reauto_step", 5'b11101);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
